// File: rtl/corelet_seq.sv
// Sequencer for the systolic-array corelet: weight load, activation execute and psum drain per kernel position.
// Optional CORELET_SEQ_PERF_EN adds a saturating L0 back-pressure stall counter (stall_cycles).
module corelet_seq #(
  parameter int ROW     = 8,
  parameter int COL     = 8,
  parameter int KIJ     = 9,
  parameter int NACT    = 36,
  parameter int ADDR_W  = 7,
  parameter int OADDR_W = 9,
  parameter int SETTLE  = 16,
  localparam int KIJ_W  = (KIJ > 1) ? $clog2(KIJ) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               seq_begin,
  input  logic               seq_abort,
  output logic               seq_busy,
  output logic               seq_done,
  output logic               w_cen,
  output logic [ADDR_W-1:0]  w_addr,
  output logic               act_cen,
  output logic [ADDR_W-1:0]  act_addr,
  output logic               aw_sel,
  output logic               l0_wr,
  output logic               l0_rd,
  input  logic               l0_full,
  output logic [1:0]         inst_w,
  output logic               array_flush,
  input  logic               ofifo_valid,
  output logic               ofifo_rd,
  output logic               op_cen,
  output logic               op_wen,
  output logic [OADDR_W-1:0] op_addr,
  output logic               acc_en,
`ifdef CORELET_SEQ_PERF_EN
  output logic [15:0]        stall_cycles,
`endif
  output logic [KIJ_W-1:0]   kij_idx
);

  // Settle must cover the array's row+column propagation.
  localparam int SETTLE_EFF = (SETTLE > ROW + COL) ? SETTLE : ROW + COL;
  localparam int CMAX  = (ROW > NACT) ? ((ROW > SETTLE_EFF) ? ROW : SETTLE_EFF)
                                      : ((NACT > SETTLE_EFF) ? NACT : SETTLE_EFF);
  localparam int CNT_W = $clog2(CMAX + 1);
  localparam int OC_W  = $clog2(NACT + 1);

  localparam logic [CNT_W-1:0] ROW_C       = CNT_W'(ROW);
  localparam logic [CNT_W-1:0] ROW_LAST    = CNT_W'(ROW - 1);
  localparam logic [CNT_W-1:0] NACT_C      = CNT_W'(NACT);
  localparam logic [CNT_W-1:0] NACT_LAST   = CNT_W'(NACT - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_EFF - 1);
  localparam logic [OC_W-1:0]  NACT_O      = OC_W'(NACT);
  localparam logic [KIJ_W-1:0] KIJ_LAST    = KIJ_W'(KIJ - 1);

  typedef enum logic [3:0] {
    IDLE, W_LOAD, W_PUSH, W_SETTLE, A_LOAD, A_PUSH, DRAIN, FLUSH, DONE
  } state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [OC_W-1:0]    o_cnt, o_cnt_n;
  logic [KIJ_W-1:0]   kij, kij_n;
  logic               aborting, aborting_n;
  logic               abort_now, stall;

  logic               w_cen_n, act_cen_n, aw_sel_n, l0_wr_n, l0_rd_n;
  logic               ofifo_rd_n, op_cen_n, op_wen_n;
  logic [ADDR_W-1:0]  w_addr_n, act_addr_n;
  logic [OADDR_W-1:0] op_addr_n;
  logic [1:0]         inst_w_n;

  assign kij_idx = kij;

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    o_cnt_n    = o_cnt;
    kij_n      = kij;
    aborting_n = aborting;
    stall      = 1'b0;
    w_cen_n    = 1'b1;
    act_cen_n  = 1'b1;
    w_addr_n   = w_addr;
    act_addr_n = act_addr;
    aw_sel_n   = aw_sel;
    l0_wr_n    = ~w_cen | ~act_cen;
    l0_rd_n    = 1'b0;
    inst_w_n   = 2'b00;
    ofifo_rd_n = 1'b0;
    op_cen_n   = 1'b1;
    op_wen_n   = 1'b1;
    op_addr_n  = op_addr;
    abort_now  = seq_abort && (state inside {W_LOAD, W_PUSH, W_SETTLE, A_LOAD, A_PUSH, DRAIN});

    case (state)
      IDLE: if (seq_begin) begin
        state_n    = W_LOAD;
        kij_n      = '0;
        cnt_n      = '0;
        o_cnt_n    = '0;
        aborting_n = 1'b0;
      end
      W_LOAD: begin
        aw_sel_n = 1'b1;
        if (cnt == ROW_C) begin
          state_n = W_PUSH;
          cnt_n   = '0;
        end else if (l0_full) begin
          stall = 1'b1;
        end else begin
          w_cen_n  = 1'b0;
          w_addr_n = ADDR_W'(int'(kij) * ROW + int'(cnt));
          cnt_n    = cnt + 1'b1;
        end
      end
      W_PUSH: begin
        l0_rd_n  = 1'b1;
        inst_w_n = 2'b01;
        if (cnt == ROW_LAST) begin
          state_n = W_SETTLE;
          cnt_n   = '0;
        end else cnt_n = cnt + 1'b1;
      end
      W_SETTLE: begin
        if (cnt == SETTLE_LAST) begin
          state_n = A_LOAD;
          cnt_n   = '0;
        end else cnt_n = cnt + 1'b1;
      end
      A_LOAD: begin
        aw_sel_n = 1'b0;
        if (cnt == NACT_C) begin
          state_n = A_PUSH;
          cnt_n   = '0;
        end else if (l0_full) begin
          stall = 1'b1;
        end else begin
          act_cen_n  = 1'b0;
          act_addr_n = ADDR_W'(cnt);
          cnt_n      = cnt + 1'b1;
        end
      end
      A_PUSH: begin
        l0_rd_n  = 1'b1;
        inst_w_n = 2'b10;
        if (cnt == NACT_LAST) begin
          state_n = DRAIN;
          cnt_n   = '0;
        end else cnt_n = cnt + 1'b1;
      end
      DRAIN: if (o_cnt == NACT_O) state_n = FLUSH;
      FLUSH: begin
        aborting_n = 1'b0;
        if (aborting) state_n = IDLE;
        else if (kij == KIJ_LAST) state_n = DONE;
        else begin
          state_n = W_LOAD;
          kij_n   = kij + 1'b1;
          cnt_n   = '0;
          o_cnt_n = '0;
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase

    // Results can arrive as soon as execution starts, so popping overlaps A_PUSH.
    if ((state inside {A_PUSH, DRAIN}) && ofifo_valid && (o_cnt != NACT_O)) begin
      ofifo_rd_n = 1'b1;
      op_cen_n   = 1'b0;
      op_wen_n   = 1'b0;
      op_addr_n  = OADDR_W'(o_cnt);
      o_cnt_n    = o_cnt + 1'b1;
    end

    if (abort_now) begin
      state_n    = FLUSH;
      aborting_n = 1'b1;
      cnt_n      = cnt;
      o_cnt_n    = o_cnt;
      stall      = 1'b0;
      w_cen_n    = 1'b1;
      act_cen_n  = 1'b1;
      l0_wr_n    = 1'b0;
      l0_rd_n    = 1'b0;
      inst_w_n   = 2'b00;
      ofifo_rd_n = 1'b0;
      op_cen_n   = 1'b1;
      op_wen_n   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      o_cnt       <= '0;
      kij         <= '0;
      aborting    <= 1'b0;
      seq_busy    <= 1'b0;
      seq_done    <= 1'b0;
      w_cen       <= 1'b1;
      act_cen     <= 1'b1;
      op_cen      <= 1'b1;
      op_wen      <= 1'b1;
      aw_sel      <= 1'b1;
      w_addr      <= '0;
      act_addr    <= '0;
      op_addr     <= '0;
      l0_wr       <= 1'b0;
      l0_rd       <= 1'b0;
      ofifo_rd    <= 1'b0;
      array_flush <= 1'b0;
      acc_en      <= 1'b0;
      inst_w      <= 2'b00;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      o_cnt       <= o_cnt_n;
      kij         <= kij_n;
      aborting    <= aborting_n;
      seq_busy    <= (state_n != IDLE);
      seq_done    <= (state_n == DONE);
      w_cen       <= w_cen_n;
      act_cen     <= act_cen_n;
      op_cen      <= op_cen_n;
      op_wen      <= op_wen_n;
      aw_sel      <= aw_sel_n;
      w_addr      <= w_addr_n;
      act_addr    <= act_addr_n;
      op_addr     <= op_addr_n;
      l0_wr       <= l0_wr_n;
      l0_rd       <= l0_rd_n;
      ofifo_rd    <= ofifo_rd_n;
      array_flush <= (state_n == FLUSH);
      acc_en      <= (state_n != IDLE) && (kij_n != '0);
      inst_w      <= inst_w_n;
    end
  end

`ifdef CORELET_SEQ_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) stall_cycles <= '0;
    else if (state == IDLE && seq_begin) stall_cycles <= '0;
    else if (stall && stall_cycles != 16'hFFFF) stall_cycles <= stall_cycles + 16'd1;
  end
`endif

endmodule
